// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter sharing one FIFO write port between NREQ requesters.
// Each grant is a burst of at most BURST words; one ARB bubble separates bursts.
module fifo_wr_arb #(
  parameter int DSIZE = 16,
  parameter int NREQ  = 4,
  parameter int BURST = 4,
  localparam int OW   = $clog2(NREQ)
) (
  input  logic                  wclk,
  input  logic                  wrst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*DSIZE-1:0] req_data,
  output logic [NREQ-1:0]       gnt,
  input  logic                  wfull,
  output logic                  winc,
  output logic [DSIZE-1:0]      wdata,
  output logic [OW-1:0]         owner,
  output logic                  busy,
  output logic [15:0]           wr_count
);

  typedef enum logic {ARB, OWN} state_t;

  state_t           state, state_next;
  logic [OW-1:0]    owner_next, last_owner, last_owner_next;
  logic [7:0]       cnt, cnt_next;
  logic             accept, found;
  logic [OW-1:0]    pick, idx;
  logic [DSIZE-1:0] sel_data;

  // Cyclic search for the first requester strictly after last_owner.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = OW'((int'(last_owner) + k) % NREQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (OW'(i) == owner) sel_data = req_data[i*DSIZE +: DSIZE];
    end
  end

  always_comb begin
    accept = 1'b0;
    winc   = 1'b0;
    gnt    = '0;
    wdata  = '0;
    if (state == OWN) begin
      accept = req[owner] & ~wfull;
      winc   = accept;
      wdata  = sel_data;
      for (int i = 0; i < NREQ; i++) begin
        gnt[i] = accept && (OW'(i) == owner);
      end
    end
  end

  always_comb begin
    state_next      = state;
    owner_next      = owner;
    last_owner_next = last_owner;
    cnt_next        = cnt;
    case (state)
      ARB: begin
        if (found) begin
          state_next      = OWN;
          owner_next      = pick;
          last_owner_next = pick;
          cnt_next        = '0;
        end
      end
      OWN: begin
        // An early release wins over everything; a full FIFO simply stalls the burst.
        if (!req[owner]) begin
          state_next = ARB;
        end else if (accept) begin
          cnt_next = cnt + 8'd1;
          if (cnt == 8'(BURST - 1)) state_next = ARB;
        end
      end
      default: state_next = ARB;
    endcase
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      state      <= ARB;
      owner      <= '0;
      last_owner <= OW'(NREQ - 1);
      cnt        <= '0;
      wr_count   <= '0;
    end else begin
      state      <= state_next;
      owner      <= owner_next;
      last_owner <= last_owner_next;
      cnt        <= cnt_next;
      if (winc && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
    end
  end

  assign busy = (state == OWN);

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Randomized bench for fifo_wr_arb against a cycle-level reference model of the
// grant rules, plus a BURST=255 instance driven into wr_count saturation.
module tb_fifo_wr_arb;

  localparam int DSIZE = 16;
  localparam int NREQ  = 4;
  localparam int BURST = 4;

  logic                  wclk;
  logic                  wrst;
  logic [NREQ-1:0]       req;
  logic [NREQ*DSIZE-1:0] req_data;
  logic [NREQ-1:0]       gnt;
  logic                  wfull;
  logic                  winc;
  logic [DSIZE-1:0]      wdata;
  logic [1:0]            owner;
  logic                  busy;
  logic [15:0]           wr_count;

  logic        sat_rst;
  logic [1:0]  sat_req;
  logic [15:0] sat_data;
  logic [1:0]  sat_gnt;
  logic        sat_winc;
  logic [7:0]  sat_wdata;
  logic        sat_owner;
  logic        sat_busy;
  logic [15:0] sat_wr_count;
  logic        sat_done;

  int checks = 0;
  int errors = 0;

  bit m_busy;
  int m_owner, m_last, m_cnt, m_wr;

  fifo_wr_arb #(.DSIZE(DSIZE), .NREQ(NREQ), .BURST(BURST)) dut (
    .wclk(wclk), .wrst(wrst), .req(req), .req_data(req_data), .gnt(gnt),
    .wfull(wfull), .winc(winc), .wdata(wdata), .owner(owner), .busy(busy),
    .wr_count(wr_count)
  );

  fifo_wr_arb #(.DSIZE(8), .NREQ(2), .BURST(255)) sat (
    .wclk(wclk), .wrst(sat_rst), .req(sat_req), .req_data(sat_data), .gnt(sat_gnt),
    .wfull(1'b0), .winc(sat_winc), .wdata(sat_wdata), .owner(sat_owner), .busy(sat_busy),
    .wr_count(sat_wr_count)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_busy  = 1'b0;
    m_owner = 0;
    m_last  = NREQ - 1;
    m_cnt   = 0;
    m_wr    = 0;
  endtask

  // Drive one cycle of inputs, compare against the model mid-cycle, then advance the model.
  task automatic applyStimulus(input logic [NREQ-1:0] r, input logic wf, input logic rs);
    bit acc;
    logic [63:0] exp_gnt;
    logic [63:0] exp_data;
    req   = r;
    wfull = wf;
    wrst  = rs;
    for (int i = 0; i < NREQ; i++) req_data[i*DSIZE +: DSIZE] = 16'($urandom);
    @(negedge wclk);
    acc      = m_busy && r[m_owner] && !wf;
    exp_gnt  = acc ? (64'd1 << m_owner) : 64'd0;
    exp_data = m_busy ? 64'(req_data[m_owner*DSIZE +: DSIZE]) : 64'd0;
    checkOutput("busy", 64'(busy), 64'(m_busy));
    checkOutput("winc", 64'(winc), 64'(acc));
    checkOutput("gnt", 64'(gnt), exp_gnt);
    checkOutput("wdata", 64'(wdata), exp_data);
    checkOutput("wr_count", 64'(wr_count), 64'(m_wr));
    if (m_busy) checkOutput("owner", 64'(owner), 64'(m_owner));
    if (rs) begin
      modelReset();
    end else if (!m_busy) begin
      for (int k = 1; k <= NREQ; k++) begin
        if (!m_busy && r[(m_last + k) % NREQ]) begin
          m_busy  = 1'b1;
          m_owner = (m_last + k) % NREQ;
          m_last  = m_owner;
          m_cnt   = 0;
        end
      end
    end else if (!r[m_owner]) begin
      m_busy = 1'b0;
    end else if (acc) begin
      if (m_wr < 65535) m_wr++;
      m_cnt++;
      if (m_cnt == BURST) m_busy = 1'b0;
    end
    @(posedge wclk);
    #1;
  endtask

  // Saturation instance: one uncontended requester, 255 words per 256 cycles.
  initial begin
    sat_done = 1'b0;
    sat_rst  = 1'b1;
    sat_req  = 2'b01;
    sat_data = 16'h00A5;
    repeat (2) @(posedge wclk);
    #1;
    sat_rst = 1'b0;
    for (int n = 1; n <= 66000; n++) begin
      @(posedge wclk);
      #1;
      if (n == 25600) checkOutput("sat_mid", 64'(sat_wr_count), 64'd25500);
      if (n == 65791) checkOutput("sat_fffe", 64'(sat_wr_count), 64'hFFFE);
      if (n == 65792) checkOutput("sat_ffff", 64'(sat_wr_count), 64'hFFFF);
      if (n == 65900) checkOutput("sat_hold", 64'(sat_wr_count), 64'hFFFF);
      if (n == 66000) checkOutput("sat_hold_end", 64'(sat_wr_count), 64'hFFFF);
    end
    sat_done = 1'b1;
  end

  initial begin
    logic [NREQ-1:0] r;
    wrst     = 1'b1;
    req      = '1;
    wfull    = 1'b0;
    req_data = '0;
    @(posedge wclk);
    #1;
    modelReset();
    applyStimulus('1, 1'b0, 1'b1);

    for (int c = 0; c < 20; c++) applyStimulus(4'hF, 1'b0, 1'b0);
    checkOutput("contention_wr16", 64'(wr_count), 64'd16);

    applyStimulus(4'b0100, 1'b0, 1'b0);
    repeat (2) applyStimulus(4'b0100, 1'b0, 1'b0);
    applyStimulus(4'b0000, 1'b0, 1'b0);
    repeat (6) applyStimulus(4'b0100, 1'b0, 1'b0);
    applyStimulus(4'b0000, 1'b0, 1'b0);

    repeat (3) applyStimulus(4'b0001, 1'b0, 1'b0);
    repeat (5) applyStimulus(4'b0001, 1'b1, 1'b0);
    repeat (3) applyStimulus(4'b0001, 1'b0, 1'b0);
    applyStimulus(4'b0000, 1'b0, 1'b0);

    repeat (12) applyStimulus(4'b1010, 1'b0, 1'b0);

    r = '0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 9) < 3) r = NREQ'($urandom_range(0, 15));
      applyStimulus(r, $urandom_range(0, 3) == 0, $urandom_range(0, 299) == 0);
    end
    req = '0;

    for (int i = 0; i < 70000 && !sat_done; i++) @(posedge wclk);
    if (!sat_done) checkOutput("sat_timeout", 64'd0, 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
